// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared constants and pixel types for the LED panel pixel
//               datapath (default geometry, counter/address widths, pixel
//               structures as laid out on the frame-buffer read port).
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    // Default panel geometry and colour depth
    localparam int DEF_COLS  = 32;
    localparam int DEF_ROWS  = 16;
    localparam int DEF_DEPTH = 4;

    // Counter and frame-buffer address widths for the default geometry
    localparam int COL_W  = $clog2(DEF_COLS);
    localparam int ROW_W  = $clog2(DEF_ROWS);
    localparam int ADDR_W = 1 + ROW_W + COL_W;

    // One pixel: r is the most significant component
    typedef struct packed {
        logic [DEF_DEPTH-1:0] r;
        logic [DEF_DEPTH-1:0] g;
        logic [DEF_DEPTH-1:0] b;
    } pixel_t;

    // Upper-half pixel in the MSBs, matching {r1,g1,b1,r0,g0,b0}
    typedef struct packed {
        pixel_t upper;
        pixel_t lower;
    } pixel_pair_t;

endpackage : led_pkg
`default_nettype wire

// File: rtl/led_pixel_datapath_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter
// Description : Modulo-MOD up counter with synchronous clear (priority over
//               enable) and a combinational terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_counter #(
    parameter  int MOD = 32,
    localparam int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         enb,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign tc    = (count_q == W'(MOD - 1));
    assign count = count_q;

    // Next count: clear wins, enable advances and wraps at terminal count
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (enb) begin
            count_d = tc ? '0 : count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : mod_counter
`default_nettype wire

// File: rtl/led_pixel_datapath.sv
`default_nettype none
// ============================================================================
// Module      : led_pixel_datapath
// Description : Column/row counters, dual-buffered frame-memory addressing,
//               buffer swap handshake and two-stage PWM serialiser for a
//               HUB75-style LED panel. DEPTH must match led_pkg::DEF_DEPTH
//               because the pixel structures are sized by the package.
//               Optional macro LED_PIXEL_DATAPATH_TEST_PATTERN_EN adds a
//               test_mode input that replaces frame data with a built-in
//               column/row gradient pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pixel_datapath
    import led_pkg::*;
#(
    parameter  int COLS  = DEF_COLS,
    parameter  int ROWS  = DEF_ROWS,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int CW    = $clog2(COLS),
    localparam int RW    = $clog2(ROWS),
    localparam int AW    = 1 + RW + CW
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef LED_PIXEL_DATAPATH_TEST_PATTERN_EN
    input  logic               test_mode,
`endif
    input  logic               colct_clr,
    input  logic               colct_enb,
    input  logic               rowct_clr,
    input  logic               rowct_enb,
    output logic               colct_eq_31,
    output logic [RW-1:0]      row_addr,
    output logic [AW-1:0]      fb_raddr,
    input  logic [6*DEPTH-1:0] fb_rdata,
    input  logic               swap_req,
    output logic               swap_ack,
    output logic               frame_start,
    output logic [5:0]         rgb
);

    // Largest frame count; the all-ones value is skipped so full scale
    // always compares greater and stays lit.
    localparam logic [DEPTH-1:0] FCT_MAX = DEPTH'((2 ** DEPTH) - 2);

    logic [CW-1:0]    colct;
    logic [RW-1:0]    rowct;
    logic             col_tc;
    logic             row_tc;
    logic             frame_evt;

    logic [DEPTH-1:0] frame_ct_q,    frame_ct_d;
    logic             buf_sel_q,     buf_sel_d;
    logic             swap_ack_q,    swap_ack_d;
    logic             frame_start_q, frame_start_d;
    logic             valid_q,       valid_d;
    logic [5:0]       rgb_q,         rgb_d;
    pixel_pair_t      pix;

    mod_counter #(.MOD(COLS)) u_col_ct (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (colct_clr),
        .enb   (colct_enb),
        .count (colct),
        .tc    (col_tc)
    );

    mod_counter #(.MOD(ROWS)) u_row_ct (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (rowct_clr),
        .enb   (rowct_enb),
        .count (rowct),
        .tc    (row_tc)
    );

    // A frame ends only on a real row wrap; a clear on the same cycle cancels it
    assign frame_evt   = rowct_enb & ~rowct_clr & row_tc;
    assign colct_eq_31 = col_tc;
    assign row_addr    = rowct;
    assign fb_raddr    = {buf_sel_q, rowct, colct};
    assign swap_ack    = swap_ack_q;
    assign frame_start = frame_start_q;
    assign rgb         = rgb_q;

    // Frame boundary: advance the PWM frame count, honour a pending swap
    always_comb begin
        frame_ct_d    = frame_ct_q;
        buf_sel_d     = buf_sel_q;
        swap_ack_d    = 1'b0;
        frame_start_d = 1'b0;
        if (frame_evt) begin
            frame_ct_d    = (frame_ct_q == FCT_MAX) ? '0 : frame_ct_q + 1'b1;
            frame_start_d = 1'b1;
            if (swap_req) begin
                buf_sel_d  = ~buf_sel_q;
                swap_ack_d = 1'b1;
            end
        end
    end

`ifdef LED_PIXEL_DATAPATH_TEST_PATTERN_EN
    // Pattern coordinates are delayed one cycle so they line up with the RAM read
    logic [CW-1:0] pat_col_q;
    logic [RW-1:0] pat_row_q;

    // Track the address that the RAM is currently returning data for
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_col_q <= '0;
            pat_row_q <= '0;
        end else begin
            pat_col_q <= colct;
            pat_row_q <= rowct;
        end
    end
`endif

    // Stage 2: select the pixel source and serialise by PWM compare
    always_comb begin
        pix = pixel_pair_t'(fb_rdata);
`ifdef LED_PIXEL_DATAPATH_TEST_PATTERN_EN
        if (test_mode) begin
            pix.upper.r = DEPTH'(pat_col_q);
            pix.upper.g = DEPTH'(pat_row_q);
            pix.upper.b = '1;
            pix.lower   = pix.upper;
        end
`endif
        valid_d = 1'b1;
        rgb_d   = rgb_q;
        if (valid_q) begin
            rgb_d = {pix.upper.r > frame_ct_q,
                     pix.upper.g > frame_ct_q,
                     pix.upper.b > frame_ct_q,
                     pix.lower.r > frame_ct_q,
                     pix.lower.g > frame_ct_q,
                     pix.lower.b > frame_ct_q};
        end
    end

    // Datapath and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_ct_q    <= '0;
            buf_sel_q     <= 1'b0;
            swap_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            valid_q       <= 1'b0;
            rgb_q         <= '0;
        end else begin
            frame_ct_q    <= frame_ct_d;
            buf_sel_q     <= buf_sel_d;
            swap_ack_q    <= swap_ack_d;
            frame_start_q <= frame_start_d;
            valid_q       <= valid_d;
            rgb_q         <= rgb_d;
        end
    end

endmodule : led_pixel_datapath
`default_nettype wire

// File: tb/tb_led_pixel_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pixel_datapath
// Description : Self-checking bench for led_pixel_datapath: a frame-RAM model,
//               a behavioural reference compared every cycle, and directed
//               literal checks. Honours LED_PIXEL_DATAPATH_TEST_PATTERN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pixel_datapath;

    localparam int COLS = 32;
    localparam int ROWS = 16;
    localparam int NFCT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        colct_clr = 1'b0, colct_enb = 1'b0;
    logic        rowct_clr = 1'b0, rowct_enb = 1'b0;
    logic        swap_req = 1'b0;
    logic        tm = 1'b0;
    logic        colct_eq_31;
    logic [3:0]  row_addr;
    logic [9:0]  fb_raddr;
    logic [23:0] fb_rdata;
    logic        swap_ack, frame_start;
    logic [5:0]  rgb;

    logic [23:0] mem [0:1023];

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_spacing = 1'b0;

    led_pixel_datapath dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef LED_PIXEL_DATAPATH_TEST_PATTERN_EN
        .test_mode   (tm),
`endif
        .colct_clr   (colct_clr),
        .colct_enb   (colct_enb),
        .rowct_clr   (rowct_clr),
        .rowct_enb   (rowct_enb),
        .colct_eq_31 (colct_eq_31),
        .row_addr    (row_addr),
        .fb_raddr    (fb_raddr),
        .fb_rdata    (fb_rdata),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .frame_start (frame_start),
        .rgb         (rgb)
    );

    always #5 clk = ~clk;

    // Synchronous-read frame RAM
    always @(posedge clk) fb_rdata <= mem[fb_raddr];

    // PWM rule: a component lights when it exceeds the frame count
    function automatic logic [5:0] pwm(input logic [23:0] d, input int f);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = (int'(d[4*i +: 4]) > f);
        return r;
    endfunction

    function automatic logic [23:0] pattern(input int c, input int r);
        logic [3:0] cc, rr;
        cc = 4'(c % 16);
        rr = 4'(r % 16);
        return {cc, rr, 4'hF, cc, rr, 4'hF};
    endfunction

    // ---------------- behavioural reference ----------------
    int          m_col, m_row, m_fct, m_n;
    logic        m_buf, m_ack, m_start;
    logic [23:0] m_ram, m_pat;
    logic [5:0]  m_rgb;
    logic        m_bnd;

    assign m_bnd = rowct_enb && !rowct_clr && (m_row == ROWS - 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_col <= 0; m_row <= 0; m_fct <= 0; m_n <= 0;
            m_buf <= 1'b0; m_ack <= 1'b0; m_start <= 1'b0;
            m_ram <= '0; m_pat <= '0; m_rgb <= '0;
        end else begin
            m_col   <= colct_clr ? 0 : (colct_enb ? (m_col + 1) % COLS : m_col);
            m_row   <= rowct_clr ? 0 : (rowct_enb ? (m_row + 1) % ROWS : m_row);
            m_fct   <= m_bnd ? (m_fct + 1) % NFCT : m_fct;
            m_buf   <= (m_bnd && swap_req) ? ~m_buf : m_buf;
            m_start <= m_bnd;
            m_ack   <= m_bnd && swap_req;
            m_ram   <= mem[{m_buf, 4'(m_row), 5'(m_col)}];
            m_pat   <= pattern(m_col, m_row);
            if (m_n >= 1) m_rgb <= pwm(tm ? m_pat : m_ram, m_fct);
            if (m_n < 2) m_n <= m_n + 1;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the reference
    always @(negedge clk) begin
        if (rst_n) begin
            cmp("model.rgb", 32'(rgb), 32'(m_rgb));
            cmp("model.fb_raddr", 32'(fb_raddr), 32'({m_buf, 4'(m_row), 5'(m_col)}));
            cmp("model.row_addr", 32'(row_addr), 32'(m_row));
            cmp("model.colct_eq_31", 32'(colct_eq_31), 32'(m_col == COLS - 1));
            cmp("model.swap_ack", 32'(swap_ack), 32'(m_ack));
            cmp("model.frame_start", 32'(frame_start), 32'(m_start));
        end
    end

    // Sequencer spacing assumption for column advances
    int cyc_cnt = 0;
    int last_enb = -100;
    always @(posedge clk) begin
        cyc_cnt++;
        if (colct_enb) begin
            if (chk_spacing) begin
                assert (cyc_cnt - last_enb >= 3)
                    else $error("column advance spacing below 3 clocks");
            end
            last_enb = cyc_cnt;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_col();
        colct_enb = 1'b1; @(negedge clk); colct_enb = 1'b0;
    endtask

    task automatic pulse_row();
        rowct_enb = 1'b1; @(negedge clk); rowct_enb = 1'b0;
    endtask

    task automatic clr_both();
        colct_clr = 1'b1; rowct_clr = 1'b1; @(negedge clk);
        colct_clr = 1'b0; rowct_clr = 1'b0;
    endtask

    task automatic fill(input logic [23:0] v);
        for (int i = 0; i < 1024; i++) mem[i] = v;
    endtask

    task automatic reset_dut();
        @(negedge clk); rst_n = 1'b0; cyc(2); rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 24'($urandom);

        // Reset state
        cyc(2);
        cmp("reset.rgb", 32'(rgb), 32'h0);
        cmp("reset.fb_raddr", 32'(fb_raddr), 32'h0);
        cmp("reset.swap_ack", 32'(swap_ack), 32'h0);
        cmp("reset.frame_start", 32'(frame_start), 32'h0);
        rst_n = 1'b1;
        cyc(2);

        // Column counter: terminal count after 31, wrap on 32nd
        for (int i = 1; i <= 31; i++) begin
            pulse_col();
            if (i == 30) cmp("col.eq31_at30", 32'(colct_eq_31), 32'h0);
        end
        cmp("col.eq31_at31", 32'(colct_eq_31), 32'h1);
        pulse_col();
        cmp("col.wrap", 32'(fb_raddr[4:0]), 32'h0);
        cmp("col.eq31_after_wrap", 32'(colct_eq_31), 32'h0);
        pulse_col(); pulse_col(); pulse_col();
        colct_clr = 1'b1; colct_enb = 1'b1; @(negedge clk);
        colct_clr = 1'b0; colct_enb = 1'b0;
        cmp("col.clr_and_enb", 32'(fb_raddr[4:0]), 32'h0);

        // Asynchronous reset mid-line at col 17, row 5
        clr_both();
        repeat (17) pulse_col();
        repeat (5) pulse_row();
        cmp("midline.addr", 32'(fb_raddr[8:0]), 32'({4'd5, 5'd17}));
        cyc(3);
        @(posedge clk); #3 rst_n = 1'b0; #1;
        cmp("async.rgb", 32'(rgb), 32'h0);
        cmp("async.fb_raddr", 32'(fb_raddr), 32'h0);
        cmp("async.row_addr", 32'(row_addr), 32'h0);
        cmp("async.eq31", 32'(colct_eq_31), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        pulse_col();
        cmp("async.resume", 32'(fb_raddr), 32'h1);

        // PWM over frames: all 8s, then 15/0/8 mix
        fill(24'h888888);
        for (int f = 0; f < 2 * NFCT; f++) begin
            if (f == NFCT) fill(24'hF08F08);
            cyc(3);
            if (f < NFCT)
                cmp("pwm.level8", 32'(rgb), 32'((f % NFCT) < 8 ? 6'h3F : 6'h00));
            else
                cmp("pwm.full_zero_8", 32'(rgb), 32'({1'b1, 1'b0, (f % NFCT) < 8, 1'b1, 1'b0, (f % NFCT) < 8}));
            repeat (ROWS) pulse_row();
            cmp("pwm.frame_start", 32'(frame_start), 32'h1);
        end

        // Buffer swap handshake
        for (int i = 0; i < 1024; i++) mem[i] = 24'($urandom);
        rowct_clr = 1'b1; @(negedge clk); rowct_clr = 1'b0;
        repeat (7) pulse_row();
        swap_req = 1'b1;
        cyc(2);
        cmp("swap.msb_before", 32'(fb_raddr[9]), 32'h0);
        repeat (8) pulse_row();
        cmp("swap.no_ack_midframe", 32'(swap_ack), 32'h0);
        cmp("swap.msb_still0", 32'(fb_raddr[9]), 32'h0);
        pulse_row();
        cmp("swap.ack", 32'(swap_ack), 32'h1);
        cmp("swap.msb_flipped", 32'(fb_raddr[9]), 32'h1);
        cyc(1);
        cmp("swap.ack_single", 32'(swap_ack), 32'h0);
        swap_req = 1'b0;
        repeat (ROWS) pulse_row();
        cmp("swap.no_second", 32'(fb_raddr[9]), 32'h1);

        // Randomised scan with model checking every cycle
        chk_spacing = 1'b1;
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 3) == 0)
                mem[$urandom_range(0, 1023)] = 24'($urandom);
            colct_clr = ($urandom_range(0, 15) == 0);
            colct_enb = 1'b1;
            @(negedge clk);
            colct_clr = 1'b0; colct_enb = 1'b0;
            for (int g = 0; g < int'($urandom_range(2, 5)); g++) begin
                rowct_enb = ($urandom_range(0, 2) == 0);
                rowct_clr = ($urandom_range(0, 31) == 0);
                if ($urandom_range(0, 7) == 0) swap_req = ~swap_req;
                @(negedge clk);
                rowct_enb = 1'b0; rowct_clr = 1'b0;
            end
        end
        chk_spacing = 1'b0;
        swap_req = 1'b0;

`ifdef LED_PIXEL_DATAPATH_TEST_PATTERN_EN
        // Built-in pattern at col 3, row 2
        reset_dut();
        tm = 1'b1;
        repeat (3) pulse_col();
        repeat (2) pulse_row();
        cyc(3);
        cmp("pattern.fct0", 32'(rgb), 32'h3F);
        repeat (3 * ROWS) pulse_row();
        cyc(3);
        cmp("pattern.fct3", 32'(rgb), 32'h09);
        tm = 1'b0;
`endif
        reset_dut();
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_led_pixel_datapath
`default_nettype wire

// File: doc/led_pixel_datapath.md
Name: led_pixel_datapath

Overview:
- Datapath partner of the panel sequencer FSM. Holds the column and row counters that the sequencer controls, and reads two pixels per column (upper and lower panel halves) from a dual-buffered frame memory.
- Converts each colour component to one serial bit per frame by PWM comparison against a frame counter. Drives the panel RGB/row-address pins and returns colct_eq_31 to the sequencer.

Parameters:
- COLS, 32, columns per row shifted per scan line (colct_eq_31 asserts at COLS-1).
- ROWS, 16, scan lines (panel half height).
- DEPTH, 4, bits per colour component; 2^DEPTH-1 brightness levels.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- colct_clr  in  1  from sequencer; clear column counter
- colct_enb  in  1  from sequencer; advance column counter
- rowct_clr  in  1  from sequencer; clear row counter
- rowct_enb  in  1  from sequencer; advance row counter
- colct_eq_31  out  1  combinational, colct == COLS-1
- row_addr  out  $clog2(ROWS)  panel A/B/C/D lines, equals row counter
- fb_raddr  out  1+$clog2(ROWS)+$clog2(COLS)  {buf_sel, row, col} to frame RAM
- fb_rdata  in  6*DEPTH  {r1,g1,b1,r0,g0,b0} components; valid 1 cycle after fb_raddr
- swap_req  in  1  level; writer has filled back buffer
- swap_ack  out  1  one-cycle pulse when buffer swap takes effect
- frame_start  out  1  one-cycle pulse when row wraps to 0
- rgb  out  6  {r1,g1,b1,r0,g0,b0} serial bits, registered

Behaviour:
- Reset (async, rst_n=0): colct=0, rowct=0, frame_ct=0, buf_sel=0, rgb=0, swap_ack=0, frame_start=0, internal pipeline valid cleared. Reset mid-scan aborts the line; there is no partial-state recovery.
- Column counter: clr has priority over enb. enb at COLS-1 wraps to 0.
- Row counter: same priority rules. rowct_enb at ROWS-1 wraps to 0 and is the frame boundary event.
- Frame boundary (same cycle as wrap):
  - frame_ct increments modulo 2^DEPTH-1, skipping the all-ones value so that full scale is always on.
  - frame_start pulses on the next cycle.
  - If swap_req=1: buf_sel toggles and swap_ack pulses on the next cycle.
  - swap_req seen on a non-boundary cycle has no effect. The writer holds swap_req until it sees swap_ack and deasserts it within one frame.
- fb_raddr is combinational from {buf_sel, rowct, colct}.
- Pipeline:
  - Stage 1: RAM returns fb_rdata.
  - Stage 2: rgb[i] <= (component_i > frame_ct) for each of the 6 components.
  - Latency from a counter change to rgb update is 2 clocks. The sequencer half-period (half_enb spacing) must be ≥3 clocks; the bench checks this assumption with an assertion.
- Component value 0 gives a bit that is never set. Value 2^DEPTH-1 gives a bit that is always set.
- frame_ct is sampled per pixel and changes only at the frame boundary, so it is stable for an entire frame.
- colct_clr and colct_enb asserted together: counter goes to 0.
- rowct_clr asserted on a boundary cycle: no frame event and no swap.

Optional Feature:
- Macro: LED_PIXEL_DATAPATH_TEST_PATTERN_EN.
- When defined:
  - Adds input test_mode (1 bit).
  - When test_mode=1, stage-2 components are replaced by an internal pattern: r = col[DEPTH-1:0], g = row[DEPTH-1:0], b = full scale, for both halves.
  - fb_rdata is ignored in this mode. Swap logic and counters are unchanged.
- When undefined: the test_mode port does not exist and the path is always fb_rdata.

Decomposition:
- Package led_pkg:
  - COLS, ROWS, DEPTH defaults.
  - COL_W, ROW_W, ADDR_W localparams.
  - typedef pixel_t (struct of r, g, b, each DEPTH bits).
  - typedef pixel_pair_t (upper, lower).
- One sub-module, mod_counter: parameterised modulus, clr/enb with clr priority, terminal-count output. Instantiated twice, for column and row.
- The PWM compare stays inline.

Test Plan:
- Reset asserted mid-line (colct=17, rowct=5) → all outputs 0 immediately, without waiting for clk; counters resume from 0 after release.
- 32 colct_enb pulses → colct_eq_31 high exactly after the 31st; the 32nd wraps colct to 0. colct_clr+colct_enb together → 0.
- Frame RAM: all components 4'h8, DEPTH=4 → rgb=6'b111111 for frames with frame_ct 0–7, 0 for frames 8–14; 15-frame period. Value 0 is never on; 15 is always on.
- swap_req raised mid-frame → buf_sel toggles only at the next row wrap; swap_ack is a single pulse; fb_raddr MSB flips; held swap_req without a new request causes no further swap after deassert.
- Address/data pipeline: distinct per-address RAM model → rgb matches expected compare exactly 2 clocks after each colct change.
- With LED_PIXEL_DATAPATH_TEST_PATTERN_EN, test_mode=1, frame_ct=0, col=3, row=2 → r0=r1=1, g0=g1=1, b0=b1=1; at frame_ct=3 → r=0, g=0, b=1.
